// File: rtl/julia_iter_engine_pkg.sv
// Shared types and helpers for the Julia iteration engine.
//   julia_state_t : engine FSM states
//   escape_limit  : |z|^2 escape threshold (4.0) in fixed point with frac bits
//   sat_fx        : clamp a wide signed value into a signed width-bit range
// Datapath math is done in 64-bit signed, so WIDTH must stay <= 31.
package julia_pkg;

  typedef enum logic [1:0] {IDLE, SQUARE, UPDATE, DONE} julia_state_t;

  localparam int FRAC_DEFAULT = 11;

  function automatic logic signed [63:0] escape_limit(input int frac);
    return 64'sd4 <<< frac;
  endfunction

  localparam logic signed [63:0] ESCAPE_LIMIT_DEFAULT = escape_limit(FRAC_DEFAULT);

  function automatic logic signed [63:0] sat_fx(input logic signed [63:0] value,
                                                input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v)      return max_v;
    else if (value < min_v) return min_v;
    else                    return value;
  endfunction

endpackage

// File: rtl/julia_iter_engine_if.sv
// Job/result handshake bundle for julia_iter_engine.
//   master : dispatcher/collector side (offers jobs, accepts results)
//   slave  : engine side
interface julia_iter_engine_if #(
  parameter int WIDTH  = 22,
  parameter int ITER_W = 8,
  parameter int TAG_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] z_real_in;
  logic signed [WIDTH-1:0] z_imag_in;
  logic signed [WIDTH-1:0] c_real_in;
  logic signed [WIDTH-1:0] c_imag_in;
  logic [TAG_W-1:0]        tag_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [ITER_W-1:0]       iter_out;
  logic                    escaped_out;
  logic [TAG_W-1:0]        tag_out;

  modport master (
    output in_valid, z_real_in, z_imag_in, c_real_in, c_imag_in, tag_in, out_ready,
    input  in_ready, out_valid, iter_out, escaped_out, tag_out
  );

  modport slave (
    input  in_valid, z_real_in, z_imag_in, c_real_in, c_imag_in, tag_in, out_ready,
    output in_ready, out_valid, iter_out, escaped_out, tag_out
  );
endinterface

// File: rtl/julia_iter_engine_z_square_stage.sv
// Registered full-precision squaring stage.
//   clk, n_rst : clock, async active-low reset
//   en         : capture products this cycle
//   zr, zi     : current z (signed WIDTH)
//   rr, ii, ri : zr^2, zi^2, zr*zi (signed 2*WIDTH, registered)
module z_square_stage
  import julia_pkg::*;
#(
  parameter int WIDTH = 22
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   zr,
  input  logic signed [WIDTH-1:0]   zi,
  output logic signed [2*WIDTH-1:0] rr,
  output logic signed [2*WIDTH-1:0] ii,
  output logic signed [2*WIDTH-1:0] ri
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rr <= '0;
      ii <= '0;
      ri <= '0;
    end else if (en) begin
      rr <= (2*WIDTH)'(zr) * (2*WIDTH)'(zr);
      ii <= (2*WIDTH)'(zi) * (2*WIDTH)'(zi);
      ri <= (2*WIDTH)'(zr) * (2*WIDTH)'(zi);
    end
  end

endmodule

// File: rtl/julia_iter_engine.sv
// Sequential Julia escape-time engine: takes one (z0, c, tag) job, iterates
// z <- z^2 + c until |z|^2 > 4.0 or MAX_ITER updates, then returns the count.
//   clk, n_rst : clock, async active-low reset
//   bus        : job in / result out handshakes (slave side)
//   busy       : engine not idle
//
// state  | meaning
// IDLE   | waiting for a job, in_ready high
// SQUARE | products of current z being registered
// UPDATE | escape/cap test, then z update or finish
// DONE   | result held on outputs until out_ready
module julia_iter_engine
  import julia_pkg::*;
#(
  parameter int WIDTH    = 22,
  parameter int FRAC     = 11,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int TAG_W    = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  julia_iter_engine_if.slave  bus,
  output logic                busy
);

  julia_state_t state, state_next;

  logic signed [WIDTH-1:0]   zr, zi, cr, ci;
  logic [ITER_W-1:0]         iter;
  logic [TAG_W-1:0]          tag;
  logic signed [2*WIDTH-1:0] rr, ii, ri;

  logic signed [63:0] size_sq, re_sum, im_sum;
  logic               escape, cap;

  z_square_stage #(.WIDTH(WIDTH)) u_square (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (state == SQUARE),
    .zr    (zr),
    .zi    (zi),
    .rr    (rr),
    .ii    (ii),
    .ri    (ri)
  );

  // Shifts are arithmetic (floor); |z|^2 is compared unsaturated so huge
  // magnitudes can never alias back under the limit.
  always_comb begin
    size_sq = (64'(rr) + 64'(ii)) >>> FRAC;
    re_sum  = ((64'(rr) - 64'(ii)) >>> FRAC) + 64'(cr);
    im_sum  = ((64'(ri) <<< 1) >>> FRAC) + 64'(ci);
    escape  = size_sq > escape_limit(FRAC);
    cap     = (iter == ITER_W'(MAX_ITER));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_next = SQUARE;
      end
      SQUARE: state_next = UPDATE;
      UPDATE: state_next = (escape || cap) ? DONE : SQUARE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      zr              <= '0;
      zi              <= '0;
      cr              <= '0;
      ci              <= '0;
      iter            <= '0;
      tag             <= '0;
      bus.iter_out    <= '0;
      bus.escaped_out <= 1'b0;
      bus.tag_out     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            zr   <= bus.z_real_in;
            zi   <= bus.z_imag_in;
            cr   <= bus.c_real_in;
            ci   <= bus.c_imag_in;
            tag  <= bus.tag_in;
            iter <= '0;
          end
        end
        UPDATE: begin
          if (escape || cap) begin
            bus.iter_out    <= iter;
            bus.escaped_out <= escape;
            bus.tag_out     <= tag;
          end else begin
            zr   <= WIDTH'(sat_fx(re_sum, WIDTH));
            zi   <= WIDTH'(sat_fx(im_sum, WIDTH));
            iter <= iter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/julia_iter_engine.md
# julia_iter_engine

Parametrised, sequential successor to the combinational single-step Julia z-calculator. It accepts one pixel job (z0, c, tag) over a valid/ready handshake. It iterates z ← z² + c in signed fixed point until |z|² exceeds 4.0 or the iteration cap is reached, then returns the escape count and tag over a second valid/ready handshake. It sits between the Julia worker's pixel dispatcher and its result collector; several instances run in parallel.

## Interface
- WIDTH, 22: total bits of every signed fixed-point operand.
- FRAC, 11: fractional bits (integer bits = WIDTH − FRAC).
- ITER_W, 8: iteration counter width.
- MAX_ITER, 255: iteration cap, must be ≤ 2^ITER_W − 1.
- TAG_W, 16: opaque pixel tag width.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  engine can accept a job.
- z_real_in, z_imag_in  in  WIDTH  signed z0.
- c_real_in, c_imag_in  in  WIDTH  signed c.
- tag_in  in  TAG_W  pixel tag.
- out_valid  out  1  result available.
- out_ready  in  1  collector accepts result.
- iter_out  out  ITER_W  number of z updates performed.
- escaped_out  out  1  1 = |z|² > 4.0 terminated; 0 = cap reached.
- tag_out  out  TAG_W  tag of the job.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, SQUARE, UPDATE, DONE.
- IDLE: in_ready=1. in_valid at a clock edge captures z0, c, tag, clears iter, and moves to SQUARE.
- SQUARE: registers the full-precision signed products rr=zr², ii=zi², ri=zr·zi, each 2·WIDTH bits. Then moves to UPDATE.
- UPDATE computes:
  - size_sq = (rr+ii) >>> FRAC, kept at 2·WIDTH+1 bits and never saturated.
  - If size_sq > (4 << FRAC), strictly greater: escaped=1, go to DONE.
  - Else if iter == MAX_ITER: escaped=0, go to DONE.
  - Else: zr ← sat((rr−ii) >>> FRAC + cr), zi ← sat((ri <<< 1) >>> FRAC + ci), iter++, go to SQUARE.
- Escape is checked on the current z before each update, so z0 itself can escape with iter_out=0.
- Shifts are arithmetic and truncate toward −∞.
- sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. There is no wrap-around.
- DONE: out_valid=1. iter_out, escaped_out and tag_out stay stable until out_ready.
  - out_valid && out_ready at an edge → IDLE.
  - in_ready stays 0 in DONE. A new job is accepted only from IDLE, so at most one job is in flight.
- Reset (async, any state) → IDLE. All outputs reset: in_ready=1, out_valid=0, iter_out=0, escaped_out=0, tag_out=0, busy=0. An in-flight job is discarded with no output.

## Timing
- Each iteration takes 2 cycles (SQUARE + UPDATE).
- Accept edge E0; out_valid rises 2k+2 cycles after E0, where k = final iter_out.
- No-escape worst case: 2·MAX_ITER+2 = 512 cycles at default.
- Minimum accept-to-accept spacing: 2k+4 cycles (DONE handshake at earliest edge, then IDLE for one cycle).
- Outputs are driven from registers only. in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.

## Structure
- Package julia_pkg holds:
  - state enum julia_state_t {IDLE, SQUARE, UPDATE, DONE};
  - function sat_fx(value, WIDTH);
  - localparam escape-limit helper (4 << FRAC).
- One sub-module z_square_stage: registered products rr/ii/ri, parametrised on WIDTH.
- FSM, update adder/saturation and output registers stay in julia_iter_engine.

## Test plan
- z0=(2048,1024) [1.0+0.5i], c=(−1024,1024) [−0.5+0.5i] → z1=(512,3072), z2=(−5504,2560). Result iter_out=2, escaped_out=1; out_valid 6 cycles after accept.
- z0=(4096,0) [2.0], c=(0,0) → size_sq exactly 4.0 does not escape; z1=(8192,0). Result iter_out=1, escaped_out=1, latency 4.
- z0=(0,0), c=(0,0) → iter_out=255, escaped_out=0, out_valid at cycle 512. in_valid held high throughout is ignored until the engine returns to IDLE.
- z0=(4096,0), c=(2097151,0) → z1 real saturates to 2097151 (no wrap to negative). Result iter_out=1, escaped_out=1.
- Back-pressure: out_ready=0 for 20 cycles in DONE → out_valid, iter_out and tag_out hold; in_ready=0. Then out_ready=1 → IDLE next edge; the tag of the next job (0xBEEF) appears on its own result.
- Assert n_rst low mid-iteration (async, between edges) → outputs take reset values immediately. After release, the next job completes correctly with no residue from the aborted one.
